// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Optional macro BIN_TO_BCD_SELFCHECK_EN adds a registered digit_err flag on the result.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
`ifdef BIN_TO_BCD_SELFCHECK_EN
    ,
    output logic                  digit_err
`endif
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = add3_if_ge5(s[4*i +: 4]);
        end
        return r;
    endfunction

`ifdef BIN_TO_BCD_SELFCHECK_EN
    function automatic logic any_digit_bad(input logic [BCD_W-1:0] s);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (s[4*i+3] & (s[4*i+2] | s[4*i+1]));
        end
        return bad;
    endfunction
`endif

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     scratch_q, scratch_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
`ifdef BIN_TO_BCD_SELFCHECK_EN
    logic                 digit_err_q, digit_err_d;
`endif

    logic [BCD_W-1:0]     corrected;
    logic [BCD_W-1:0]     scratch_shl;
    logic [BIN_WIDTH-1:0] bin_shl;
    logic                 shift_out;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
`ifdef BIN_TO_BCD_SELFCHECK_EN
        digit_err_d = digit_err_q;
`endif
        // Carry out of the top digit is dropped, leaving the result modulo 10^DIGITS.
        corrected = correct_digits(scratch_q);
        {shift_out, scratch_shl, bin_shl} = {corrected, bin_q, 1'b0};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_WIDTH);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bin_d     = bin_shl;
                scratch_d = scratch_shl;
                ovf_acc_d = ovf_acc_q | shift_out;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scratch_shl;
                    ovf_d   = ovf_acc_q | shift_out;
`ifdef BIN_TO_BCD_SELFCHECK_EN
                    digit_err_d = any_digit_bad(scratch_shl);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            scratch_q <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef BIN_TO_BCD_SELFCHECK_EN
            digit_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
`ifdef BIN_TO_BCD_SELFCHECK_EN
            digit_err_q <= digit_err_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;
`ifdef BIN_TO_BCD_SELFCHECK_EN
    assign digit_err = digit_err_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: 3-digit and 2-digit instances share clk/reset/start/bin_in.
// Honours BIN_TO_BCD_SELFCHECK_EN by connecting and checking digit_err.
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
`ifdef BIN_TO_BCD_SELFCHECK_EN
    logic        derr3, derr2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .ovf(ovf3)
`ifdef BIN_TO_BCD_SELFCHECK_EN
        , .digit_err(derr3)
`endif
    );

    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2)
`ifdef BIN_TO_BCD_SELFCHECK_EN
        , .digit_err(derr2)
`endif
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic        ovf2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: value modulo 10^d, packed as BCD digits.
    function automatic logic [19:0] ref_bcd(input int v, input int d);
        int r;
        logic [19:0] res;
        r = v % (10 ** d);
        res = '0;
        for (int i = 0; i < d; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    function automatic logic ref_ovf(input int v, input int d);
        return v >= (10 ** d);
    endfunction

    task automatic convert(input string name, input logic [7:0] v,
                           input logic [11:0] e3, input logic eo3,
                           input logic [7:0] e2, input logic eo2);
        int lat;
        logic [11:0] prev3;
        logic busy_ok, stable_ok;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'($urandom);
        prev3 = bcd3;
        busy_ok = 1'b1;
        stable_ok = 1'b1;
        lat = 0;
        while (!done3 && lat < 40) begin
            if (!busy3) busy_ok = 1'b0;
            if (bcd3 !== prev3) stable_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, 8);
        chk({name, " busy_in_shift"}, busy_ok, 1);
        chk({name, " bcd_hold"}, stable_ok, 1);
        chk({name, " done2"}, done2, 1);
        chk({name, " bcd3"}, bcd3, e3);
        chk({name, " ovf3"}, ovf3, eo3);
        chk({name, " bcd2"}, bcd2, e2);
        chk({name, " ovf2"}, ovf2, eo2);
`ifdef BIN_TO_BCD_SELFCHECK_EN
        chk({name, " digit_err3"}, derr3, 0);
        chk({name, " digit_err2"}, derr2, 0);
`endif
        @(negedge clk);
        chk({name, " done_pulse"}, done3, 0);
        chk({name, " idle"}, busy3, 0);
    endtask

    initial begin
        int cnt, ndone;
        logic [7:0] rv;
        logic [11:0] cap;

        vecs[0] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1};
        vecs[2] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0};
        vecs[3] = '{8'd10,  12'h010, 1'b0, 8'h10, 1'b0};
        vecs[4] = '{8'd200, 12'h200, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'd123, 12'h123, 1'b0, 8'h23, 1'b1};
        vecs[6] = '{8'd100, 12'h100, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'd7,   12'h007, 1'b0, 8'h07, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst busy", busy3, 0);
        chk("rst done", done3, 0);
        chk("rst bcd", bcd3, 0);
        chk("rst ovf", ovf3, 0);
        chk("rst bcd2", bcd2, 0);

        foreach (vecs[i])
            convert("vec", vecs[i].bin, vecs[i].bcd3, vecs[i].ovf3, vecs[i].bcd2, vecs[i].ovf2);

        for (int i = 0; i < 30; i++) begin
            rv = 8'($urandom_range(0, 255));
            convert("rand", rv, 12'(ref_bcd(rv, 3)), ref_ovf(rv, 3), 8'(ref_bcd(rv, 2)), ref_ovf(rv, 2));
        end

        // Start re-pulsed during the 3rd SHIFT cycle must be ignored, not queued.
        @(negedge clk); start = 1'b1; bin_in = 8'd200;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; bin_in = 8'd7;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        cap = '0;
        for (int i = 0; i < 25; i++) begin
            if (done3) begin ndone++; cap = bcd3; end
            @(negedge clk);
        end
        chk("repulse done_count", ndone, 1);
        chk("repulse bcd", cap, 12'h200);
        chk("repulse idle", busy3, 0);

        // Start held high: one IDLE cycle between back-to-back conversions.
        @(negedge clk); start = 1'b1; bin_in = 8'd5;
        cnt = 0;
        while (!done3 && cnt < 40) begin @(negedge clk); cnt++; end
        chk("b2b first_done", done3, 1);
        @(negedge clk);
        cnt = 1;
        while (!done3 && cnt < 40) begin @(negedge clk); cnt++; end
        start = 1'b0;
        chk("b2b period", cnt, 10);
        chk("b2b bcd", bcd3, 12'h005);
        repeat (2) @(negedge clk);

        // Reset in the 4th SHIFT cycle aborts with no done pulse.
        convert("pre_abort", 8'd200, 12'h200, 1'b0, 8'h00, 1'b1);
        @(negedge clk); start = 1'b1; bin_in = 8'd200;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("abort busy", busy3, 0);
        chk("abort bcd", bcd3, 0);
        chk("abort ovf2", ovf2, 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done3 || busy3) ndone++;
            @(negedge clk);
        end
        chk("abort no_done", ndone, 0);
        convert("after_abort", 8'd42, 12'h042, 1'b0, 8'h42, 1'b0);

        // Exhaustive sweep against the decimal reference.
        for (int v = 0; v < 256; v++)
            convert("sweep", 8'(v), 12'(ref_bcd(v, 3)), ref_ovf(v, 3), 8'(ref_bcd(v, 2)), ref_ovf(v, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
